// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester memory arbiter. The instruction-fetch unit (IFU, read only)
// and the load/store unit (LSU, read or write) share one memory port.
// Requests are granted round-robin, one at a time. Each granted transaction
// passes through a four-state FSM:
//   IDLE -> REQ  -> WAIT -> RESP -> IDLE
// so back-to-back throughput is at most one transaction every four cycles.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a WAIT-state counter forces a response with resp_err=1 and
//   resp_rdata=0 after TIMEOUT cycles without mem_resp_valid. When undefined,
//   resp_err is tied low and WAIT waits for memory indefinitely.
//
// Parameters
//   LATCH_W  width of the address, write-data and read-data fields
//   TIMEOUT  WAIT cycles before a forced error response (ARB_TIMEOUT_EN only)
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   ifu_req_valid/ready        IFU fetch request handshake
//   ifu_addr                   fetch address
//   lsu_req_valid/ready        LSU request handshake
//   lsu_addr/wen/wdata/type    LSU address, write enable, store data, size
//   ifu_resp_valid             one-cycle IFU completion pulse
//   lsu_resp_valid             one-cycle LSU completion pulse
//   resp_rdata, resp_err       response data and timeout flag
//   mem_req_valid/ready        memory request handshake
//   mem_addr/wen/wdata/mask    registered transaction fields
//   mem_resp_valid, mem_rdata  memory completion and read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LATCH_W = 64,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [LATCH_W-1:0] ifu_addr,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [LATCH_W-1:0] lsu_addr,
    input  logic               lsu_wen,
    input  logic [LATCH_W-1:0] lsu_wdata,
    input  logic [3:0]         lsu_type,
    output logic               ifu_resp_valid,
    output logic               lsu_resp_valid,
    output logic [LATCH_W-1:0] resp_rdata,
    output logic               resp_err,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [LATCH_W-1:0] mem_addr,
    output logic               mem_wen,
    output logic [LATCH_W-1:0] mem_wdata,
    output logic [7:0]         mem_mask,
    input  logic               mem_resp_valid,
    input  logic [LATCH_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q;
    logic               last_lsu_q;     // 1: LSU was granted most recently
    logic               owner_lsu_q;    // 1: current transaction belongs to LSU
    logic [LATCH_W-1:0] addr_q;
    logic [LATCH_W-1:0] wdata_q;
    logic [LATCH_W-1:0] rdata_q;
    logic               wen_q;
    logic [7:0]         mask_q;
    logic               mem_req_valid_q;
    logic               ifu_resp_q;
    logic               lsu_resp_q;

    logic               grant_ifu_d;
    logic               grant_lsu_d;
    logic [LATCH_W-1:0] addr_d;
    logic [LATCH_W-1:0] wdata_d;
    logic               wen_d;
    logic [7:0]         mask_d;
    logic [7:0]         lsu_mask;
    logic               timeout_hit;

    // Byte enables from the access size; sizes of 8 or more shift every bit
    // out, which yields a full mask.
    assign lsu_mask = ~(8'hFF << lsu_type);

    // Grant only in IDLE and only while out of reset, so nothing is accepted
    // before the first rising edge with rst released. On a tie the requester
    // not granted last wins.
    always_comb begin
        grant_ifu_d = 1'b0;
        grant_lsu_d = 1'b0;
        if (state_q == IDLE && rst) begin
            if (ifu_req_valid && (!lsu_req_valid || last_lsu_q)) begin
                grant_ifu_d = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu_d = 1'b1;
            end
        end
    end

    assign addr_d  = grant_lsu_d ? lsu_addr  : ifu_addr;
    assign wdata_d = grant_lsu_d ? lsu_wdata : '0;
    assign wen_d   = grant_lsu_d & lsu_wen;
    assign mask_d  = grant_lsu_d ? lsu_mask  : 8'h0F;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Counter holds the number of WAIT cycles already completed; the last
    // allowed WAIT cycle is the one where it reads TIMEOUT-1.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign resp_err    = err_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign resp_err       = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            last_lsu_q      <= 1'b1;   // IFU wins the first tie
            owner_lsu_q     <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            wen_q           <= 1'b0;
            mask_q          <= 8'h00;
            mem_req_valid_q <= 1'b0;
            ifu_resp_q      <= 1'b0;
            lsu_resp_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q      <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ifu_d || grant_lsu_d) begin
                        state_q         <= REQ;
                        addr_q          <= addr_d;
                        wdata_q         <= wdata_d;
                        wen_q           <= wen_d;
                        mask_q          <= mask_d;
                        owner_lsu_q     <= grant_lsu_d;
                        last_lsu_q      <= grant_lsu_d;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_q         <= WAIT;
                        mem_req_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt_q      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state_q    <= RESP;
                        rdata_q    <= wen_q ? '0 : mem_rdata;
                        ifu_resp_q <= ~owner_lsu_q;
                        lsu_resp_q <= owner_lsu_q;
`ifdef ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end else if (timeout_hit) begin
                        state_q    <= RESP;
                        rdata_q    <= '0;
                        ifu_resp_q <= ~owner_lsu_q;
                        lsu_resp_q <= owner_lsu_q;
`ifdef ARB_TIMEOUT_EN
                        err_q      <= 1'b1;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                end
                RESP: begin
                    state_q    <= IDLE;
                    ifu_resp_q <= 1'b0;
                    lsu_resp_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ifu_req_ready  = grant_ifu_d;
    assign lsu_req_ready  = grant_lsu_d;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_mask       = mask_q;
    assign ifu_resp_valid = ifu_resp_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed and randomized transactions against mem_arbiter. Expected grants,
// fields, masks and response data come from a small reference model that
// applies the arbitration and masking rules directly (last-granted flag, size
// lookup). Build with ARB_TIMEOUT_EN defined to also exercise the timeout.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        lsu_req_valid, lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [3:0]  lsu_type;
    logic        ifu_resp_valid, lsu_resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int checks = 0;
    int passed = 0;
    int txn_no = 0;
    bit model_last_lsu;   // reference model: LSU granted most recently

    always #5 clk = ~clk;

    mem_arbiter #(
        .LATCH_W(64),
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_type      (lsu_type),
        .ifu_resp_valid(ifu_resp_valid),
        .lsu_resp_valid(lsu_resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_mask      (mem_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Byte-enable mask for an access of t bytes.
    function automatic logic [7:0] exp_lsu_mask(input logic [3:0] t);
        if (t >= 4'd8) return 8'hFF;
        return 8'((1 << t) - 1);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One complete transaction: offer requests in IDLE, hold mem_req_ready
    // low for rd REQ cycles, give the response after rs extra WAIT cycles.
    task automatic run_txn(input bit iv, input bit lv,
                           input logic [63:0] iaddr, input logic [63:0] laddr,
                           input bit wen, input logic [63:0] wdata,
                           input logic [3:0] ltype, input int rd, input int rs,
                           input logic [63:0] rdata);
        bit          e_lsu;
        logic [63:0] e_addr, e_rdata;
        logic [7:0]  e_mask;
        bit          e_wen;
        if (iv && lv) e_lsu = !model_last_lsu;
        else          e_lsu = lv;
        model_last_lsu = e_lsu;
        e_addr  = e_lsu ? laddr : iaddr;
        e_wen   = e_lsu && wen;
        e_mask  = e_lsu ? exp_lsu_mask(ltype) : 8'h0F;
        e_rdata = e_wen ? 64'd0 : rdata;

        // IDLE: offer the request(s)
        @(posedge clk); #1;
        ifu_req_valid  = iv;
        ifu_addr       = iaddr;
        lsu_req_valid  = lv;
        lsu_addr       = laddr;
        lsu_wen        = wen;
        lsu_wdata      = wdata;
        lsu_type       = ltype;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'($urandom);
        mem_rdata      = rnd64();
        @(negedge clk);
        chk("ifu_ready", ifu_req_ready, !e_lsu);
        chk("lsu_ready", lsu_req_ready, e_lsu);
        chk("idle_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);

        // REQ: inputs scrambled, fields must stay put
        for (int k = 0; k <= rd; k++) begin
            @(posedge clk); #1;
            ifu_req_valid  = 1'($urandom);
            lsu_req_valid  = 1'($urandom);
            ifu_addr       = rnd64();
            lsu_addr       = rnd64();
            lsu_wdata      = rnd64();
            lsu_wen        = 1'($urandom);
            lsu_type       = 4'($urandom);
            mem_req_ready  = (k == rd);
            mem_resp_valid = 1'($urandom);
            @(negedge clk);
            chk("req_valid", mem_req_valid, 1);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wen", mem_wen, e_wen);
            chk("mem_mask", mem_mask, e_mask);
            if (e_lsu) chk("mem_wdata", mem_wdata, wdata);
            chk("req_no_ready", {ifu_req_ready, lsu_req_ready}, 0);
            chk("req_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        end

        // WAIT
        for (int k = 0; k <= rs; k++) begin
            @(posedge clk); #1;
            mem_req_ready  = 1'($urandom);
            mem_resp_valid = (k == rs);
            mem_rdata      = (k == rs) ? rdata : rnd64();
            @(negedge clk);
            chk("wait_req_low", mem_req_valid, 0);
            chk("wait_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        end

        // RESP
        @(posedge clk); #1;
        mem_resp_valid = 1'($urandom);
        mem_rdata      = rnd64();
        @(negedge clk);
        chk("ifu_resp", ifu_resp_valid, !e_lsu);
        chk("lsu_resp", lsu_resp_valid, e_lsu);
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_err", resp_err, 0);
        chk("resp_no_ready", {ifu_req_ready, lsu_req_ready}, 0);
        txn_no++;
        $display("txn %0d: iv=%0b lv=%0b grant=%s wen=%0b addr=0x%0h mask=0x%02h rd=%0d rs=%0d rdata=0x%0h",
                 txn_no, iv, lv, e_lsu ? "LSU" : "IFU", e_wen, e_addr, e_mask, rd, rs, resp_rdata);
    endtask

    initial begin
        logic [3:0] sizes [5];
        sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0};

        rst            = 1'b0;
        ifu_req_valid  = 1'b1;   // requests during reset must not be accepted
        lsu_req_valid  = 1'b1;
        ifu_addr       = 64'h1;
        lsu_addr       = 64'h2;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_type       = 4'd1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        model_last_lsu = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_mask", mem_mask, 0);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid, resp_err}, 0);
        chk("rst_rdata", resp_rdata, 0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst = 1'b1;

        // IFU read with immediate ready/response
        run_txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 4'd1, 0, 0, 64'h1234);
        // LSU halfword write
        run_txn(0, 1, 64'h0, 64'h8000_0010, 1, 64'hABCD, 4'd2, 0, 0, 64'hDEAD_BEEF);
        // Memory stalls the request for five cycles
        run_txn(1, 0, 64'h8000_0100, 64'h0, 0, 64'h0, 4'd1, 5, 1, rnd64());

        // Asynchronous reset while in WAIT
        @(posedge clk); #1;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b0;
        ifu_addr       = 64'h8000_0200;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;          // accepted, now in REQ
        ifu_req_valid = 1'b0;
        @(posedge clk); #1;          // now in WAIT
        mem_req_ready = 1'b0;
        ifu_req_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req_valid", mem_req_valid, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_mask", mem_mask, 0);
        chk("arst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("arst_resp", {ifu_resp_valid, lsu_resp_valid, resp_err}, 0);
        model_last_lsu = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_resp_valid = 1'b1;
            mem_rdata      = rnd64();
            @(negedge clk);
            chk("post_rst_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            chk("post_rst_idle", mem_req_valid, 0);
        end
        mem_resp_valid = 1'b0;

        // Both requesters valid continuously: IFU, LSU, IFU, LSU
        for (int k = 0; k < 4; k++) begin
            run_txn(1, 1, 64'h8000_1000 + 64'(k * 4), 64'h8000_2000 + 64'(k * 8),
                    1'(k), rnd64(), 4'd8, 0, 0, rnd64());
        end

`ifdef ARB_TIMEOUT_EN
        // Memory never responds: forced error after four WAIT cycles
        @(posedge clk); #1;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b0;
        ifu_addr       = 64'h8000_3000;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        model_last_lsu = 1'b0;
        @(posedge clk); #1;          // REQ
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        mem_rdata     = 64'hFFFF_0000_1111_2222;
        @(posedge clk); #1;          // first WAIT cycle
        mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_ifu_resp", ifu_resp_valid, 1);
        chk("to_resp_err", resp_err, 1);
        chk("to_rdata", resp_rdata, 0);
        txn_no++;
        $display("txn %0d: IFU timeout err=%0b rdata=0x%0h", txn_no, resp_err, resp_rdata);
`endif

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            bit         iv, lv;
            logic [3:0] t;
            iv = 1'($urandom);
            lv = 1'($urandom);
            if (!iv && !lv) lv = 1'b1;
            t = ($urandom_range(0, 3) == 0) ? 4'($urandom) : sizes[$urandom_range(0, 4)];
            run_txn(iv, lv, rnd64(), rnd64(), 1'($urandom), rnd64(), t,
                    $urandom_range(0, 3), $urandom_range(0, 3), rnd64());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
